// File: rtl/clause_fetch_sequencer.sv
// Looks up one literal in the address translation table, then walks the returned clause mask
// and issues one clause address (base + slot) per set bit, lowest slot first, over valid/ready.
module clause_fetch_sequencer #(
  parameter int MAX_CLAUSES_PER_VARIABLE = 20,
  parameter int LITERAL_ADDRESS_WIDTH    = 11,
  parameter int SLOT_WIDTH               = 5
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                lit_valid_i,
  output logic                                lit_ready_o,
  input  logic [LITERAL_ADDRESS_WIDTH:0]      lit_i,
  output logic [LITERAL_ADDRESS_WIDTH:0]      at_index_o,
  input  logic [LITERAL_ADDRESS_WIDTH-1:0]    at_address_i,
  input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] at_mask_i,
  output logic                                ca_valid_o,
  input  logic                                ca_ready_i,
  output logic [LITERAL_ADDRESS_WIDTH-1:0]    ca_addr_o,
  output logic [SLOT_WIDTH-1:0]               ca_slot_o,
  output logic                                ca_last_o,
  output logic                                done_o,
  output logic                                empty_o
);

  localparam int MC  = MAX_CLAUSES_PER_VARIABLE;
  localparam int LAW = LITERAL_ADDRESS_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WALK} state_t;

  state_t                r_state;
  logic [LAW-1:0]        r_base;
  logic [MC-1:0]         r_rem;

  logic                  w_accept;
  logic                  w_handshake;
  logic [MC-1:0]         w_nextRem;
  logic [MC-1:0]         w_src;
  logic [LAW-1:0]        w_srcBase;
  logic [SLOT_WIDTH-1:0] w_slot;
  logic                  w_srcNonZero;
  logic                  w_srcLast;

  assign lit_ready_o = (r_state == S_IDLE);
  assign w_accept    = lit_valid_i & lit_ready_o;
  assign w_handshake = ca_valid_o & ca_ready_i;
  assign w_nextRem   = r_rem & ~(MC'(1) << ca_slot_o);

  // The first address comes straight from the AT outputs; later ones from the remaining mask.
  assign w_src     = (r_state == S_WAIT) ? at_mask_i : w_nextRem;
  assign w_srcBase = (r_state == S_WAIT) ? at_address_i : r_base;

  always_comb begin
    w_slot = '0;
    for (int i = MC - 1; i >= 0; i--) begin
      if (w_src[i]) w_slot = SLOT_WIDTH'(i);
    end
  end

  assign w_srcNonZero = |w_src;
  assign w_srcLast    = w_srcNonZero && ((w_src & (w_src - MC'(1))) == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_base     <= '0;
      r_rem      <= '0;
      at_index_o <= '0;
      ca_valid_o <= 1'b0;
      ca_addr_o  <= '0;
      ca_slot_o  <= '0;
      ca_last_o  <= 1'b0;
      done_o     <= 1'b0;
      empty_o    <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      empty_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            at_index_o <= lit_i;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          r_base <= at_address_i;
          r_rem  <= at_mask_i;
          if (w_srcNonZero) begin
            ca_valid_o <= 1'b1;
            ca_addr_o  <= w_srcBase + LAW'(w_slot);
            ca_slot_o  <= w_slot;
            ca_last_o  <= w_srcLast;
            r_state    <= S_WALK;
          end else begin
            empty_o <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_WALK: begin
          // Address sums wrap modulo the address width by design.
          if (w_handshake) begin
            r_rem <= w_nextRem;
            if (ca_last_o) begin
              ca_valid_o <= 1'b0;
              done_o     <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              ca_addr_o <= w_srcBase + LAW'(w_slot);
              ca_slot_o <= w_slot;
              ca_last_o <= w_srcLast;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_fetch_sequencer.sv
// Directed bench for clause_fetch_sequencer: a table of literals with hand-computed address
// lists, a small registered AT model, plus reset-abort and back-to-back sequences.
module tb_clause_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        lit_valid_i;
  logic        lit_ready_o;
  logic [11:0] lit_i;
  logic [11:0] at_index_o;
  logic [10:0] at_address_i;
  logic [19:0] at_mask_i;
  logic        ca_valid_o;
  logic        ca_ready_i;
  logic [10:0] ca_addr_o;
  logic [4:0]  ca_slot_o;
  logic        ca_last_o;
  logic        done_o;
  logic        empty_o;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [11:0]      lit;
    logic [10:0]      base;
    logic [19:0]      mask;
    bit               stall;
    int               n;
    logic [2:0][10:0] addr;
    logic [2:0][4:0]  slot;
  } vec_t;

  vec_t vec[6];

  logic [10:0] atBaseMem[4096];
  logic [19:0] atMaskMem[4096];

  clause_fetch_sequencer dut (
    .clk(clk), .reset(reset),
    .lit_valid_i(lit_valid_i), .lit_ready_o(lit_ready_o), .lit_i(lit_i),
    .at_index_o(at_index_o), .at_address_i(at_address_i), .at_mask_i(at_mask_i),
    .ca_valid_o(ca_valid_o), .ca_ready_i(ca_ready_i), .ca_addr_o(ca_addr_o),
    .ca_slot_o(ca_slot_o), .ca_last_o(ca_last_o), .done_o(done_o), .empty_o(empty_o)
  );

  always #5 clk = ~clk;

  // AT model: registers the entry one cycle after the index
  always @(posedge clk) begin
    at_address_i <= atBaseMem[at_index_o];
    at_mask_i    <= atMaskMem[at_index_o];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic applyStimulus(input int v);
    lit_i       = vec[v].lit;
    lit_valid_i = 1'b1;
    for (int k = 0; k < 50 && !lit_ready_o; k++) begin
      @(posedge clk); #1;
    end
    checkOutput("readyBeforeAccept", lit_ready_o, 1);
    @(posedge clk); #1;
  endtask

  task automatic walkAndCheck(input int v, input bit dropValid);
    int firstValid, got, cyc;
    bit finished;
    logic [10:0] pAddr;
    logic [4:0]  pSlot;
    logic        pLast, pValid, pReady;
    if (dropValid) lit_valid_i = 1'b0;
    firstValid = -1; got = 0; finished = 0;
    pValid = 0; pReady = 1; pAddr = '0; pSlot = '0; pLast = 0;
    checkOutput("atIndexAfterAccept", at_index_o, vec[v].lit);
    for (cyc = 0; cyc < 40 && !finished; cyc++) begin
      if (ca_valid_o && firstValid < 0) begin
        firstValid = cyc;
        checkOutput("firstValidLatency", cyc, 2);
      end
      if (pValid && !pReady) begin
        checkOutput("stallValid", ca_valid_o, 1);
        checkOutput("stallAddr", ca_addr_o, pAddr);
        checkOutput("stallSlot", ca_slot_o, pSlot);
        checkOutput("stallLast", ca_last_o, pLast);
      end
      if (done_o || empty_o) begin
        finished = 1;
        checkOutput("doneEmptyExclusive", done_o & empty_o, 0);
        checkOutput("emptyExpected", empty_o, vec[v].n == 0);
        checkOutput("issuedCount", got, vec[v].n);
        checkOutput("readyAtEnd", lit_ready_o, 1);
        checkOutput("validAtEnd", ca_valid_o, 0);
        checkOutput("atIndexHeld", at_index_o, vec[v].lit);
        if (vec[v].n == 0) begin
          checkOutput("emptyCycle", cyc, 2);
          checkOutput("noValidWhenEmpty", firstValid < 0, 1);
        end else if (!vec[v].stall) begin
          checkOutput("doneCycle", cyc, 2 + vec[v].n);
        end
      end else begin
        ca_ready_i = vec[v].stall ? (cyc % 2 == 1) : 1'b1;
        if (ca_valid_o && ca_ready_i) begin
          if (got < vec[v].n) begin
            checkOutput("caAddr", ca_addr_o, vec[v].addr[got]);
            checkOutput("caSlot", ca_slot_o, vec[v].slot[got]);
            checkOutput("caLast", ca_last_o, got == vec[v].n - 1);
          end else begin
            checkOutput("extraAddress", got, vec[v].n);
          end
          got++;
        end
        pValid = ca_valid_o; pReady = ca_ready_i;
        pAddr = ca_addr_o; pSlot = ca_slot_o; pLast = ca_last_o;
        @(posedge clk); #1;
      end
    end
    ca_ready_i = 1'b1;
    checkOutput("walkFinished", finished, 1);
    @(posedge clk); #1;
    checkOutput("pulseCleared", done_o | empty_o, 0);
  endtask

  initial begin
    bit sawDone, sawValid;
    vec[0] = '{lit:12'h005, base:11'h040, mask:20'h00025, stall:0, n:3,
               addr:{11'h045, 11'h042, 11'h040}, slot:{5'd5, 5'd2, 5'd0}};
    vec[1] = '{lit:12'h006, base:11'h040, mask:20'h00025, stall:1, n:3,
               addr:{11'h045, 11'h042, 11'h040}, slot:{5'd5, 5'd2, 5'd0}};
    vec[2] = '{lit:12'h00A, base:11'h7FE, mask:20'h80001, stall:0, n:2,
               addr:{11'h000, 11'h011, 11'h7FE}, slot:{5'd0, 5'd19, 5'd0}};
    vec[3] = '{lit:12'h003, base:11'h123, mask:20'h00000, stall:0, n:0,
               addr:{11'h000, 11'h000, 11'h000}, slot:{5'd0, 5'd0, 5'd0}};
    vec[4] = '{lit:12'hFFF, base:11'h000, mask:20'h80000, stall:0, n:1,
               addr:{11'h000, 11'h000, 11'h013}, slot:{5'd0, 5'd0, 5'd19}};
    vec[5] = '{lit:12'h100, base:11'h200, mask:20'h40102, stall:0, n:3,
               addr:{11'h212, 11'h208, 11'h201}, slot:{5'd18, 5'd8, 5'd1}};
    for (int i = 0; i < 4096; i++) begin
      atBaseMem[i] = 11'h555;
      atMaskMem[i] = 20'h0;
    end
    for (int i = 0; i < 6; i++) begin
      atBaseMem[vec[i].lit] = vec[i].base;
      atMaskMem[vec[i].lit] = vec[i].mask;
    end

    reset = 1'b1; lit_valid_i = 1'b0; lit_i = '0; ca_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetAtIndex", at_index_o, 0);
    checkOutput("resetValid", ca_valid_o, 0);
    checkOutput("resetAddr", ca_addr_o, 0);
    checkOutput("resetSlot", ca_slot_o, 0);
    checkOutput("resetLast", ca_last_o, 0);
    checkOutput("resetDoneEmpty", {done_o, empty_o}, 0);
    reset = 1'b0;
    #1;
    checkOutput("readyAfterReset", lit_ready_o, 1);

    for (int v = 0; v < 6; v++) begin
      applyStimulus(v);
      walkAndCheck(v, 1'b1);
    end

    // Back-to-back: valid stays high, second literal waits for the first one's done
    applyStimulus(5);
    lit_i = vec[2].lit;
    walkAndCheck(5, 1'b0);
    walkAndCheck(2, 1'b1);

    // Reset in the middle of a stalled walk
    ca_ready_i = 1'b0;
    applyStimulus(0);
    lit_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midWalkValid", ca_valid_o, 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abortValid", ca_valid_o, 0);
    checkOutput("abortDoneEmpty", {done_o, empty_o}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("abortReady", lit_ready_o, 1);
    ca_ready_i = 1'b1;
    sawDone = 0; sawValid = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done_o || empty_o) sawDone = 1;
      if (ca_valid_o) sawValid = 1;
    end
    checkOutput("abortNoDone", sawDone, 0);
    checkOutput("abortNoValid", sawValid, 0);
    applyStimulus(4);
    walkAndCheck(4, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: actual running required finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
